// File: rtl/esp32_spi_regmem_host_if.sv
// Bundle between the protocol processor / FPGA fabric (master) and the register/memory backend (slave).
interface esp32_spi_regmem_host_if #(
    parameter int NUM_REGS = 32,
    parameter int MEM_AW   = 8
);
    logic                    reg_wr_req;
    logic [6:0]              reg_idx;
    logic [7:0]              reg_wdata;
    logic [7:0]              reg_rdata;

    logic                    mem_wr_en;
    logic [2:0]              mem_space;
    logic [23:0]             mem_wr_addr;
    logic [7:0]              mem_wr_data;
    logic                    mem_rd_req;
    logic [2:0]              mem_rd_space;
    logic [23:0]             mem_rd_addr;
    logic                    mem_rd_valid;
    logic [7:0]              mem_rd_data;

    logic [NUM_REGS*8-1:0]   regs_out;
    logic [7:0]              status_set;
    logic                    irq;

    logic                    fab_req;
    logic                    fab_we;
    logic [2:0]              fab_space;
    logic [MEM_AW-1:0]       fab_addr;
    logic [7:0]              fab_wdata;
    logic                    fab_gnt;
    logic                    fab_rvalid;
    logic [7:0]              fab_rdata;

    modport master (
        output reg_wr_req, reg_idx, reg_wdata,
        output mem_wr_en, mem_space, mem_wr_addr, mem_wr_data,
        output mem_rd_req, mem_rd_space, mem_rd_addr,
        output status_set,
        output fab_req, fab_we, fab_space, fab_addr, fab_wdata,
        input  reg_rdata, mem_rd_valid, mem_rd_data, regs_out, irq,
        input  fab_gnt, fab_rvalid, fab_rdata
    );

    modport slave (
        input  reg_wr_req, reg_idx, reg_wdata,
        input  mem_wr_en, mem_space, mem_wr_addr, mem_wr_data,
        input  mem_rd_req, mem_rd_space, mem_rd_addr,
        input  status_set,
        input  fab_req, fab_we, fab_space, fab_addr, fab_wdata,
        output reg_rdata, mem_rd_valid, mem_rd_data, regs_out, irq,
        output fab_gnt, fab_rvalid, fab_rdata
    );
endinterface

// File: rtl/esp32_spi_regmem_host.sv
// Register file plus multi-space byte memory behind the ESP32 SPI protocol processor.
// The SPI host always wins the single memory port; the fabric waits for fab_gnt.
module esp32_spi_regmem_host #(
    parameter int NUM_REGS   = 32,
    parameter int MEM_AW     = 8,
    parameter int NUM_SPACES = 2,
    parameter int RD_LAT     = 1,
    parameter int USE_CRC    = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    esp32_spi_regmem_host_if.slave bus
);
    localparam int IDX_W     = $clog2(NUM_REGS);
    localparam int DEPTH     = 1 << MEM_AW;
    localparam int MEM_WORDS = NUM_SPACES * DEPTH;
    localparam int MEM_IW    = $clog2(MEM_WORDS);

    function automatic logic space_ok(input logic [2:0] sp);
        return {1'b0, sp} < 4'(NUM_SPACES);
    endfunction

    function automatic logic [MEM_IW-1:0] flat_idx(input logic [2:0] sp, input logic [MEM_AW-1:0] a);
        return MEM_IW'({sp, a});
    endfunction

    // ---------------- register file ----------------
    logic [7:0] status_q, status_d;
    logic [7:0] irq_en_q, irq_en_d;
    logic       irq_q;
    logic [7:0] gp_q [10:NUM_REGS-1];
    logic [7:0] reg_view [NUM_REGS];
    logic       reg_in_range;
    logic       reg_wr_hit;

    assign reg_in_range = {1'b0, bus.reg_idx} < 8'(NUM_REGS);
    assign reg_wr_hit   = bus.reg_wr_req & reg_in_range;

    // Sticky set is applied after the W1C clear so a same-cycle set survives.
    always_comb begin
        status_d = status_q;
        irq_en_d = irq_en_q;
        if (reg_wr_hit && bus.reg_idx == 7'd8) status_d = status_q & ~bus.reg_wdata;
        status_d = status_d | bus.status_set;
        if (reg_wr_hit && bus.reg_idx == 7'd9) irq_en_d = bus.reg_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= 8'h00;
            irq_en_q <= 8'h00;
            irq_q    <= 1'b0;
            for (int k = 10; k < NUM_REGS; k++) gp_q[k] <= 8'h00;
        end else begin
            status_q <= status_d;
            irq_en_q <= irq_en_d;
            irq_q    <= |(status_d & irq_en_d);
            for (int k = 10; k < NUM_REGS; k++) begin
                if (reg_wr_hit && bus.reg_idx == 7'(k)) gp_q[k] <= bus.reg_wdata;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) reg_view[k] = 8'h00;
        reg_view[0] = 8'h41;
        reg_view[1] = 8'h32;
        reg_view[2] = 8'h46;
        reg_view[3] = 8'h50;
        reg_view[4] = 8'h02;
        reg_view[5] = 8'(((USE_CRC != 0) ? 2 : 0) + 1);
        reg_view[6] = 8'(MEM_AW);
        reg_view[7] = 8'(NUM_SPACES);
        reg_view[8] = status_q;
        reg_view[9] = irq_en_q;
        for (int k = 10; k < NUM_REGS; k++) reg_view[k] = gp_q[k];
    end

    assign bus.reg_rdata = reg_in_range ? reg_view[bus.reg_idx[IDX_W-1:0]] : 8'h00;
    assign bus.irq       = irq_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign bus.regs_out[8*g +: 8] = reg_view[g];
    end

    // ---------------- memory port arbitration ----------------
    logic              host_active;
    logic              fab_gnt;
    logic              mem_we;
    logic [MEM_IW-1:0] mem_widx;
    logic [7:0]        mem_wdata;
    logic [MEM_IW-1:0] mem_ridx;
    logic              rd_host;
    logic              rd_fab;
    logic              rd_oob;

    assign host_active = bus.mem_wr_en | bus.mem_rd_req;
    assign fab_gnt     = bus.fab_req & ~host_active;
    assign bus.fab_gnt = fab_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = flat_idx(bus.mem_space, bus.mem_wr_addr[MEM_AW-1:0]);
        mem_wdata = bus.mem_wr_data;
        if (bus.mem_wr_en) begin
            mem_we = space_ok(bus.mem_space);
        end else if (fab_gnt && bus.fab_we) begin
            mem_we    = space_ok(bus.fab_space);
            mem_widx  = flat_idx(bus.fab_space, bus.fab_addr);
            mem_wdata = bus.fab_wdata;
        end
        rd_host = bus.mem_rd_req;
        rd_fab  = fab_gnt & ~bus.fab_we;
        if (rd_host) begin
            mem_ridx = flat_idx(bus.mem_rd_space, bus.mem_rd_addr[MEM_AW-1:0]);
            rd_oob   = ~space_ok(bus.mem_rd_space);
        end else begin
            mem_ridx = flat_idx(bus.fab_space, bus.fab_addr);
            rd_oob   = ~space_ok(bus.fab_space);
        end
    end

    // Host address bits above MEM_AW are intentionally dropped (address wrap).
    logic unused_addr_hi;
    assign unused_addr_hi = ^{bus.mem_wr_addr, bus.mem_rd_addr};

    // ---------------- storage (no reset, BRAM-friendly, read-first) ----------------
    logic [7:0] mem [MEM_WORDS];
    logic [7:0] rd_raw_q;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_widx] <= mem_wdata;
        rd_raw_q <= mem[mem_ridx];
    end

    // ---------------- read pipelines ----------------
    logic [RD_LAT-1:0] host_v_q;
    logic [RD_LAT-1:0] fab_v_q;
    logic              rd_oob_q;
    logic [7:0]        rd_byte;
    logic [7:0]        host_data;
    logic [7:0]        fab_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_v_q <= '0;
            fab_v_q  <= '0;
            rd_oob_q <= 1'b0;
        end else begin
            host_v_q[0] <= rd_host;
            fab_v_q[0]  <= rd_fab;
            rd_oob_q    <= rd_oob;
            for (int k = 1; k < RD_LAT; k++) begin
                host_v_q[k] <= host_v_q[k-1];
                fab_v_q[k]  <= fab_v_q[k-1];
            end
        end
    end

    assign rd_byte = rd_oob_q ? 8'hFF : rd_raw_q;

    if (RD_LAT == 1) begin : g_lat1
        assign host_data = rd_byte;
        assign fab_data  = rd_byte;
    end else begin : g_latn
        logic [7:0] host_pipe_q [1:RD_LAT-1];
        logic [7:0] fab_pipe_q  [1:RD_LAT-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 1; k < RD_LAT; k++) begin
                    host_pipe_q[k] <= 8'h00;
                    fab_pipe_q[k]  <= 8'h00;
                end
            end else begin
                host_pipe_q[1] <= rd_byte;
                fab_pipe_q[1]  <= rd_byte;
                for (int k = 2; k < RD_LAT; k++) begin
                    host_pipe_q[k] <= host_pipe_q[k-1];
                    fab_pipe_q[k]  <= fab_pipe_q[k-1];
                end
            end
        end

        assign host_data = host_pipe_q[RD_LAT-1];
        assign fab_data  = fab_pipe_q[RD_LAT-1];
    end

    // Data is forced to zero outside valid so reset and idle outputs read 0x00.
    assign bus.mem_rd_valid = host_v_q[RD_LAT-1];
    assign bus.mem_rd_data  = host_v_q[RD_LAT-1] ? host_data : 8'h00;
    assign bus.fab_rvalid   = fab_v_q[RD_LAT-1];
    assign bus.fab_rdata    = fab_v_q[RD_LAT-1] ? fab_data : 8'h00;
endmodule

// File: tb/tb_esp32_spi_regmem_host.sv
// Scoreboard bench for esp32_spi_regmem_host: directed scenarios plus randomized host/fabric traffic.
module tb_esp32_spi_regmem_host;
    localparam int NUM_REGS   = 32;
    localparam int MEM_AW     = 8;
    localparam int NUM_SPACES = 2;
    localparam int RD_LAT     = 3;
    localparam int USE_CRC    = 0;
    localparam int DEPTH      = 1 << MEM_AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    esp32_spi_regmem_host_if #(.NUM_REGS(NUM_REGS), .MEM_AW(MEM_AW)) bus ();

    esp32_spi_regmem_host #(
        .NUM_REGS(NUM_REGS), .MEM_AW(MEM_AW), .NUM_SPACES(NUM_SPACES),
        .RD_LAT(RD_LAT), .USE_CRC(USE_CRC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    int   edge_n   = 0;
    exp_t host_q[$];
    exp_t fab_q[$];

    logic [7:0] mem_m [NUM_SPACES][DEPTH];
    logic [7:0] id_tab [8] = '{8'h41, 8'h32, 8'h46, 8'h50, 8'h02, 8'h01, 8'h08, 8'h02};
    logic [7:0] gp_m [128];
    logic [7:0] st_m, ie_m;
    logic       irq_m;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at edge %0d: actual=%0h required=%0h", nm, edge_n, act, req);
        end
    endtask

    function automatic logic [7:0] view(input int idx);
        if (idx >= NUM_REGS) return 8'h00;
        if (idx < 8) return id_tab[idx];
        if (idx == 8) return st_m;
        if (idx == 9) return ie_m;
        return gp_m[idx];
    endfunction

    function automatic logic [7:0] m_rd(input logic [2:0] sp, input logic [23:0] a);
        if (int'(sp) >= NUM_SPACES) return 8'hFF;
        return mem_m[int'(sp)][int'(a) % DEPTH];
    endfunction

    function automatic void m_wr(input logic [2:0] sp, input logic [23:0] a, input logic [7:0] d);
        if (int'(sp) < NUM_SPACES) mem_m[int'(sp)][int'(a) % DEPTH] = d;
    endfunction

    // Monitor: every falling edge, compare both read ports against the expected queues.
    logic host_exp, fab_exp;
    always @(negedge clk) begin
        host_exp = (host_q.size() != 0) && (host_q[0].due == edge_n);
        chk("host_rd_valid", 32'(bus.mem_rd_valid), 32'(host_exp));
        if (host_exp) begin
            chk("host_rd_data", 32'(bus.mem_rd_data), 32'(host_q[0].data));
            void'(host_q.pop_front());
        end
        fab_exp = (fab_q.size() != 0) && (fab_q[0].due == edge_n);
        chk("fab_rvalid", 32'(bus.fab_rvalid), 32'(fab_exp));
        if (fab_exp) begin
            chk("fab_rdata", 32'(bus.fab_rdata), 32'(fab_q[0].data));
            void'(fab_q.pop_front());
        end
    end

    // Apply one clock of whatever is currently driven; update the model with the same effect.
    task automatic commit();
        logic       host_act, exp_gnt;
        logic [7:0] clr;
        exp_t       e;
        int         idx;
        host_act = bus.mem_wr_en | bus.mem_rd_req;
        exp_gnt  = bus.fab_req & ~host_act;
        #1;
        chk("fab_gnt", 32'(bus.fab_gnt), 32'(exp_gnt));
        if (bus.mem_rd_req) begin
            e.data = m_rd(bus.mem_rd_space, bus.mem_rd_addr);
            e.due  = edge_n + RD_LAT;
            host_q.push_back(e);
        end
        if (exp_gnt && !bus.fab_we) begin
            e.data = m_rd(bus.fab_space, 24'(bus.fab_addr));
            e.due  = edge_n + RD_LAT;
            fab_q.push_back(e);
        end
        if (bus.mem_wr_en) m_wr(bus.mem_space, bus.mem_wr_addr, bus.mem_wr_data);
        if (exp_gnt && bus.fab_we) m_wr(bus.fab_space, 24'(bus.fab_addr), bus.fab_wdata);
        idx = int'(bus.reg_idx);
        clr = (bus.reg_wr_req && idx == 8) ? bus.reg_wdata : 8'h00;
        st_m = (st_m & ~clr) | bus.status_set;
        if (bus.reg_wr_req && idx == 9) ie_m = bus.reg_wdata;
        if (bus.reg_wr_req && idx >= 10 && idx < NUM_REGS) gp_m[idx] = bus.reg_wdata;
        irq_m = |(st_m & ie_m);
        @(posedge clk);
        #1;
        bus.mem_wr_en  = 1'b0;
        bus.mem_rd_req = 1'b0;
        bus.reg_wr_req = 1'b0;
        bus.status_set = 8'h00;
        if (exp_gnt) bus.fab_req = 1'b0;
        chk("irq", 32'(bus.irq), 32'(irq_m));
        chk("reg_rdata", 32'(bus.reg_rdata), 32'(view(int'(bus.reg_idx))));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        host_q.delete();
        fab_q.delete();
        st_m = 8'h00; ie_m = 8'h00; irq_m = 1'b0;
        for (int k = 0; k < 128; k++) gp_m[k] = 8'h00;
        bus.mem_wr_en = 1'b0; bus.mem_rd_req = 1'b0; bus.reg_wr_req = 1'b0;
        bus.status_set = 8'h00; bus.fab_we = 1'b0; bus.fab_req = 1'b1;
        #1;
        chk("rst_fab_gnt", 32'(bus.fab_gnt), 32'd1);
        chk("rst_irq", 32'(bus.irq), 32'd0);
        chk("rst_rd_valid", 32'(bus.mem_rd_valid), 32'd0);
        chk("rst_fab_rvalid", 32'(bus.fab_rvalid), 32'd0);
        chk("rst_rd_data", 32'(bus.mem_rd_data), 32'd0);
        chk("rst_fab_rdata", 32'(bus.fab_rdata), 32'd0);
        bus.fab_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_all_regs(input string nm);
        for (int k = 0; k < NUM_REGS; k++) begin
            chk(nm, 32'(bus.regs_out[8*k +: 8]), 32'(view(k)));
        end
    endtask

    initial begin
        bus.reg_wr_req = 0; bus.reg_idx = 0; bus.reg_wdata = 0;
        bus.mem_wr_en = 0; bus.mem_space = 0; bus.mem_wr_addr = 0; bus.mem_wr_data = 0;
        bus.mem_rd_req = 0; bus.mem_rd_space = 0; bus.mem_rd_addr = 0;
        bus.status_set = 0;
        bus.fab_req = 0; bus.fab_we = 0; bus.fab_space = 0; bus.fab_addr = 0; bus.fab_wdata = 0;
        #2;
        do_reset();

        // Identification registers and read-only protection
        for (int k = 0; k < 8; k++) begin
            bus.reg_idx = 7'(k);
            #1;
            chk("id_reg", 32'(bus.reg_rdata), 32'(id_tab[k]));
        end
        bus.reg_wr_req = 1; bus.reg_idx = 7'd2; bus.reg_wdata = 8'h55;
        commit();
        chk("ro_reg2", 32'(bus.reg_rdata), 32'h46);

        // Give every byte of both spaces a known value
        for (int s = 0; s < NUM_SPACES; s++) begin
            for (int a = 0; a < DEPTH; a++) begin
                bus.mem_wr_en = 1; bus.mem_space = 3'(s);
                bus.mem_wr_addr = {16'($urandom), 8'(a)};
                bus.mem_wr_data = 8'($urandom);
                commit();
            end
        end

        // STATUS sticky set, set-beats-clear, irq
        bus.reg_wr_req = 1; bus.reg_idx = 7'd9; bus.reg_wdata = 8'h04;
        commit();
        bus.status_set = 8'h04; bus.reg_idx = 7'd8;
        commit();
        chk("irq_set", 32'(bus.irq), 32'd1);
        bus.status_set = 8'h04; bus.reg_wr_req = 1; bus.reg_idx = 7'd8; bus.reg_wdata = 8'h04;
        commit();
        chk("set_wins", 32'(bus.reg_rdata), 32'h04);
        bus.reg_wr_req = 1; bus.reg_idx = 7'd8; bus.reg_wdata = 8'h04;
        commit();
        chk("irq_clear", 32'(bus.irq), 32'd0);

        // Address wrap and back-to-back reads with read-after-write
        bus.mem_wr_en = 1; bus.mem_space = 3'd1; bus.mem_wr_addr = 24'h0001FF; bus.mem_wr_data = 8'hA5;
        commit();
        for (int i = 0; i < 4; i++) begin
            bus.mem_rd_req = 1; bus.mem_rd_space = 3'd1; bus.mem_rd_addr = 24'h0000FF;
            commit();
        end
        for (int i = 0; i < 4; i++) commit();

        // Fabric read held off by five host reads
        bus.fab_req = 1; bus.fab_we = 0; bus.fab_space = 3'd0; bus.fab_addr = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            bus.mem_rd_req = 1; bus.mem_rd_space = 3'd0; bus.mem_rd_addr = 24'(i * 7);
            commit();
        end
        #1;
        chk("fab_gnt_after_host", 32'(bus.fab_gnt), 32'd1);
        commit();
        for (int i = 0; i < 4; i++) commit();

        // Unmapped space and unmapped register index
        bus.mem_rd_req = 1; bus.mem_rd_space = 3'd7; bus.mem_rd_addr = 24'h123456;
        commit();
        bus.reg_wr_req = 1; bus.reg_idx = 7'd100; bus.reg_wdata = 8'hC3;
        commit();
        chk("unmapped_rd", 32'(bus.reg_rdata), 32'h00);
        check_all_regs("regs_out_unmapped");

        // Randomized mixed traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 3) begin
                bus.mem_wr_en = 1; bus.mem_space = 3'($urandom_range(0, 2));
                bus.mem_wr_addr = 24'($urandom); bus.mem_wr_data = 8'($urandom);
            end else if (r < 6) begin
                bus.mem_rd_req = 1; bus.mem_rd_space = ($urandom_range(0, 7) == 0) ? 3'd7 : 3'($urandom_range(0, 1));
                bus.mem_rd_addr = 24'($urandom);
            end
            if (!bus.fab_req && $urandom_range(0, 2) == 0) begin
                bus.fab_req = 1; bus.fab_we = 1'($urandom);
                bus.fab_space = 3'($urandom_range(0, 3));
                bus.fab_addr = 8'($urandom); bus.fab_wdata = 8'($urandom);
            end
            bus.reg_idx = 7'($urandom_range(0, 40));
            if ($urandom_range(0, 9) < 3) begin
                bus.reg_wr_req = 1; bus.reg_wdata = 8'($urandom);
            end
            if ($urandom_range(0, 4) == 0) bus.status_set = 8'($urandom);
            commit();
        end
        for (int i = 0; i < 6; i++) commit();
        check_all_regs("regs_out_random");

        // Reset one cycle after a host read: the read must never appear
        bus.mem_rd_req = 1; bus.mem_rd_space = 3'd0; bus.mem_rd_addr = 24'h000010;
        commit();
        do_reset();
        for (int i = 0; i < 6; i++) commit();
        check_all_regs("regs_out_after_reset");
        chk("irq_after_reset", 32'(bus.irq), 32'd0);

        // Memory survives reset
        bus.mem_rd_req = 1; bus.mem_rd_space = 3'd1; bus.mem_rd_addr = 24'h0000FF;
        commit();
        for (int i = 0; i < RD_LAT + 2; i++) commit();
        chk("host_q_drained", 32'(host_q.size()), 32'd0);
        chk("fab_q_drained", 32'(fab_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
